// File: rtl/up_counter_mod_pkg.sv
// Shared types for the modulo-N up counter.
package up_counter_mod_pkg;

   // Action taken on a rising edge, already resolved by priority.
   typedef enum logic [1:0] {
      ACT_HOLD  = 2'd0,
      ACT_COUNT = 2'd1,
      ACT_LOAD  = 2'd2,
      ACT_CLEAR = 2'd3
   } act_e;

endpackage

// File: rtl/up_counter_mod_count_cell.sv
// One counter bit: toggle flop with synchronous clear/load, async active-low reset.
module count_cell (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic load,
   input  logic d,
   input  logic t,
   output logic q
);

   // Bit register; clear beats load beats toggle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= 1'b0;
      end else if (clr) begin
         q <= 1'b0;
      end else if (load) begin
         q <= d;
      end else if (t) begin
         q <= ~q;
      end
   end

endmodule

// File: rtl/up_counter_mod.sv
// Modulo-N up counter with enable, load, clear, terminal count and wrap/overflow flags.
module up_counter_mod
   import up_counter_mod_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             wrap,
   output logic             ovf,
   output logic             load_err
);

   localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

   act_e             act;
   logic             at_term;
   logic             load_ok;
   logic             wrap_set;
   logic             cell_clr;
   logic             cell_load;
   logic [WIDTH-1:0] carry;

   assign at_term = (out == TERM);
   assign load_ok = (32'(load_val) < MODULUS);

   // Resolve the edge action by priority clr > load > en > hold.
   always_comb begin
      act = ACT_HOLD;
      if (clr) begin
         act = ACT_CLEAR;
      end else if (load) begin
         act = ACT_LOAD;
      end else if (en) begin
         act = ACT_COUNT;
      end
   end

   // Cell controls: an out-of-range load and the terminal-count step both clear to zero.
   always_comb begin
      wrap_set  = (act == ACT_COUNT) && at_term;
      cell_load = (act == ACT_LOAD) && load_ok;
      cell_clr  = (act == ACT_CLEAR) || ((act == ACT_LOAD) && !load_ok) || wrap_set;
   end

   // Ripple of "all lower bits are one" used as the per-bit toggle condition.
   always_comb begin
      carry[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         carry[i] = carry[i-1] & out[i-1];
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      count_cell u_cell (
         .clk  (clk),
         .rst  (rst),
         .clr  (cell_clr),
         .load (cell_load),
         .d    (load_val[g]),
         .t    ((act == ACT_COUNT) && !at_term && carry[g]),
         .q    (out[g])
      );
   end

   // Carry-out for cascading; deliberately ignores load and clr.
   assign tc = en && at_term;

   // Status flags: wrap and load_err are single-cycle pulses, ovf is sticky.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrap     <= 1'b0;
         ovf      <= 1'b0;
         load_err <= 1'b0;
      end else begin
         wrap     <= wrap_set;
         load_err <= (act == ACT_LOAD) && !load_ok;
         if (act == ACT_CLEAR) begin
            ovf <= 1'b0;
         end else if (wrap_set) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule
